// File: rtl/tdm_mux_scan.sv
// N-to-1 word selector with registered output and valid/ready handshakes.
// MANUAL forwards one chosen channel; SCAN snapshots every channel and serialises them.
module tdm_mux_scan #(
  parameter int OUT_DATA_WIDTH = 21,
  parameter int NUM_IN         = 8,
  parameter int SEL_WIDTH      = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_IN*OUT_DATA_WIDTH-1:0] in_flat,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             mode,
  input  logic [SEL_WIDTH-1:0]             sel,
  output logic [OUT_DATA_WIDTH-1:0]        out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SEL_WIDTH-1:0]             out_sel,
  output logic                             out_last
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SEL_WIDTH-1:0] LAST_SEL   = SEL_WIDTH'(NUM_IN - 1);
  localparam logic                 FIRST_LAST = (NUM_IN == 1);

  state_t                    state;
  logic [OUT_DATA_WIDTH-1:0] ch   [NUM_IN];
  logic [OUT_DATA_WIDTH-1:0] hold [NUM_IN];
  logic [OUT_DATA_WIDTH-1:0] sel_word;
  logic [OUT_DATA_WIDTH-1:0] hold_word;
  logic [SEL_WIDTH-1:0]      next_sel;
  logic                      accept;
  logic                      xfer;

  // A frame's last word may be replaced in the same cycle it is consumed.
  assign in_ready = !out_valid | (out_ready & out_last);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;
  assign next_sel = out_sel + 1'b1;

  // Out-of-range selects match no channel and therefore yield zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    sel_word  = '0;
    hold_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      ch[i] = in_flat[i*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
      if (sel == SEL_WIDTH'(i))      sel_word  = ch[i];
      if (next_sel == SEL_WIDTH'(i)) hold_word = hold[i];
    end
  end

  // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      // NOTE: the snapshot bank is reset on purpose; it is small and a known value after reset is required.
      for (int i = 0; i < NUM_IN; i++) hold[i] <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      if (mode) begin
        for (int i = 0; i < NUM_IN; i++) hold[i] <= ch[i];
        out_data <= ch[0];
        out_sel  <= '0;
        out_last <= FIRST_LAST;
        state    <= SCAN;
      end else begin
        out_data <= sel_word;
        out_sel  <= sel;
        out_last <= 1'b1;
        state    <= IDLE;
      end
    end else if (xfer) begin
      if (out_last) begin
        // out_data deliberately keeps the final word.
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        state     <= IDLE;
      end else if (state == SCAN) begin
        out_sel  <= next_sel;
        out_data <= hold_word;
        out_last <= (next_sel == LAST_SEL);
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux_scan.sv
// Self-checking bench for tdm_mux_scan: directed vector table, corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_tdm_mux_scan;

  localparam int W  = 21;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int N6 = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*W-1:0]  in_flat = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            mode = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [SW-1:0]   out_sel;
  logic            out_last;

  logic [N6*W-1:0] in_flat6 = '0;
  logic            in_valid6 = 1'b0;
  logic            in_ready6;
  logic [SW-1:0]   sel6 = '0;
  logic [W-1:0]    out_data6;
  logic            out_valid6;
  logic [SW-1:0]   out_sel6;
  logic            out_last6;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tdm_mux_scan #(.OUT_DATA_WIDTH(W), .NUM_IN(N), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_flat(in_flat), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel), .out_last(out_last)
  );

  tdm_mux_scan #(.OUT_DATA_WIDTH(W), .NUM_IN(N6), .SEL_WIDTH(SW)) dut6 (
    .clk(clk), .rst(rst), .in_flat(in_flat6), .in_valid(in_valid6), .in_ready(in_ready6),
    .mode(1'b0), .sel(sel6), .out_data(out_data6), .out_valid(out_valid6),
    .out_ready(1'b1), .out_sel(out_sel6), .out_last(out_last6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int base, input int step);
    for (int i = 0; i < N; i++) in_flat[i*W +: W] = W'(base + i*step);
  endtask

  typedef struct {
    logic [SW-1:0] sel;
    logic [W-1:0]  exp_data;
  } man_vec_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
    logic          last;
  } word_t;

  man_vec_t vecs[4];
  word_t    q[$];
  logic [W-1:0] last_data;

  initial begin
    vecs[0] = '{sel: 3'd3, exp_data: 21'd53};
    vecs[1] = '{sel: 3'd0, exp_data: 21'd5};
    vecs[2] = '{sel: 3'd7, exp_data: 21'd117};
    vecs[3] = '{sel: 3'd5, exp_data: 21'd85};

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data), 0);
    check("rst_out_sel",   32'(out_sel), 0);
    check("rst_out_last",  32'(out_last), 0);
    check("rst_in_ready",  32'(in_ready), 1);
    #21 rst = 1'b0;
    tick();

    // MANUAL vector table, channels i*16+5
    set_ch(5, 16);
    out_ready = 1'b1;
    foreach (vecs[v]) begin
      in_valid = 1'b1;
      mode     = 1'b0;
      sel      = vecs[v].sel;
      tick();
      in_valid = 1'b0;
      check("man_valid", 32'(out_valid), 1);
      check("man_data",  32'(out_data), 32'(vecs[v].exp_data));
      check("man_sel",   32'(out_sel), 32'(vecs[v].sel));
      check("man_last",  32'(out_last), 1);
      check("man_ready", 32'(in_ready), 1);
    end
    tick();
    check("man_drain_valid", 32'(out_valid), 0);
    check("man_drain_hold",  32'(out_data), 85);

    // SCAN, out_ready high throughout
    set_ch(100, 1);
    in_valid = 1'b1;
    mode     = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("scan_data",  32'(out_data), 32'(100 + k));
      check("scan_sel",   32'(out_sel), 32'(k));
      check("scan_last",  32'(out_last), 32'(k == N-1));
      check("scan_ready", 32'(in_ready), 32'(k == N-1));
      tick();
    end
    check("scan_end_valid", 32'(out_valid), 0);
    check("scan_end_data",  32'(out_data), 107);

    // SCAN with a 3-cycle stall on word 2
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("stall_data", 32'(out_data), 32'(100 + k));
      check("stall_sel",  32'(out_sel), 32'(k));
      if (k == 2) begin
        out_ready = 1'b0;
        #1 check("stall_in_ready", 32'(in_ready), 0);
        repeat (3) begin
          tick();
          check("stall_hold_valid", 32'(out_valid), 1);
          check("stall_hold_data",  32'(out_data), 102);
          check("stall_hold_sel",   32'(out_sel), 2);
          check("stall_hold_last",  32'(out_last), 0);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    check("stall_end_valid", 32'(out_valid), 0);

    // Back-to-back SCAN frames; second beat waits with new channel values
    in_valid = 1'b1;
    tick();
    set_ch(200, 1);
    for (int k = 0; k < 2*N; k++) begin
      check("b2b_valid", 32'(out_valid), 1);
      check("b2b_data",  32'(out_data), 32'(k < N ? 100 + k : 200 + k - N));
      check("b2b_sel",   32'(out_sel), 32'(k % N));
      check("b2b_last",  32'(out_last), 32'(k % N == N-1));
      if (k == N) in_valid = 1'b0;
      tick();
    end
    check("b2b_end_valid", 32'(out_valid), 0);

    // Out-of-range select on a 6-channel instance
    for (int i = 0; i < N6; i++) in_flat6[i*W +: W] = W'(i*16 + 5);
    in_valid6 = 1'b1;
    sel6      = 3'd7;
    tick();
    check("oor_data", 32'(out_data6), 0);
    check("oor_sel",  32'(out_sel6), 7);
    check("oor_last", 32'(out_last6), 1);
    sel6 = 3'd5;
    tick();
    in_valid6 = 1'b0;
    check("n6_data", 32'(out_data6), 85);
    check("n6_sel",  32'(out_sel6), 5);

    // Asynchronous reset mid-frame
    set_ch(100, 1);
    in_valid = 1'b1;
    mode     = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("abort_pre_data", 32'(out_data), 32'(100 + k));
      if (k < 4) tick();
    end
    #2 rst = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 0);
    check("abort_sel",   32'(out_sel), 0);
    check("abort_data",  32'(out_data), 0);
    check("abort_last",  32'(out_last), 0);
    #3 rst = 1'b0;
    #1 check("abort_in_ready", 32'(in_ready), 1);
    repeat (3) begin
      tick();
      check("abort_no_stale", 32'(out_valid), 0);
    end

    // Randomized traffic against a frame-queue model
    last_data = '0;
    for (int c = 0; c < 1500; c++) begin
      logic acc, xfr, exp_ready;
      in_valid  = ($urandom % 4) != 0;
      mode      = 1'($urandom % 2);
      sel       = SW'($urandom);
      out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) in_flat[i*W +: W] = W'($urandom);
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
      check("rnd_in_ready",  32'(in_ready), 32'(exp_ready));
      check("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("rnd_data", 32'(out_data), 32'(q[0].data));
        check("rnd_sel",  32'(out_sel), 32'(q[0].sel));
        check("rnd_last", 32'(out_last), 32'(q[0].last));
      end else begin
        check("rnd_idle_last", 32'(out_last), 0);
        check("rnd_idle_data", 32'(out_data), 32'(last_data));
      end
      acc = in_valid && exp_ready;
      xfr = (q.size() != 0) && out_ready;
      @(posedge clk);
      if (xfr) begin
        last_data = q[0].data;
        void'(q.pop_front());
      end
      if (acc) begin
        if (mode) begin
          for (int i = 0; i < N; i++)
            q.push_back('{data: in_flat[i*W +: W], sel: SW'(i), last: (i == N-1)});
        end else begin
          q.push_back('{data: (int'(sel) < N) ? in_flat[int'(sel)*W +: W] : W'(0),
                        sel: sel, last: 1'b1});
        end
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
